// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for the dynamic branch predictor: lookup, training,
// mispredict redirect and statistics.
interface branch_predictor_if #(
    parameter int PC_W   = 64,
    parameter int STAT_W = 32
);
    logic [PC_W-1:0]   if_pc;
    logic              pred_hit;
    logic              pred_taken;
    logic [PC_W-1:0]   pred_target;

    logic              upd_valid;
    logic              upd_is_jump;
    logic [PC_W-1:0]   upd_pc;
    logic              upd_taken;
    logic [PC_W-1:0]   upd_target;
    logic              upd_pred_taken;
    logic [PC_W-1:0]   upd_pred_target;

    logic              flush;
    logic [PC_W-1:0]   redirect_pc;

    logic              clear_stats;
    logic [STAT_W-1:0] stat_branches;
    logic [STAT_W-1:0] stat_mispredicts;

    modport master (
        output if_pc,
        output upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
        output upd_pred_taken, upd_pred_target,
        output clear_stats,
        input  pred_hit, pred_taken, pred_target,
        input  flush, redirect_pc,
        input  stat_branches, stat_mispredicts
    );

    modport slave (
        input  if_pc,
        input  upd_valid, upd_is_jump, upd_pc, upd_taken, upd_target,
        input  upd_pred_taken, upd_pred_target,
        input  clear_stats,
        output pred_hit, pred_taken, pred_target,
        output flush, redirect_pc,
        output stat_branches, stat_mispredicts
    );
endinterface

// File: rtl/branch_predictor.sv
// Tagged BTB with saturating direction counters: combinational lookup for fetch,
// edge-triggered training from execute, mispredict flush/redirect and event stats.
module branch_predictor #(
    parameter int PC_W    = 64,
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    branch_predictor_if.slave bp
);
    localparam int IDX_W = $clog2(ENTRIES);

    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_WEAK_T  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_NT = CNT_WEAK_T - CNT_W'(1);
    localparam logic [PC_W-1:0]  PC_STEP     = PC_W'(4);

    logic              entry_valid  [ENTRIES];
    logic [TAG_W-1:0]  entry_tag    [ENTRIES];
    logic [PC_W-1:0]   entry_target [ENTRIES];
    logic [CNT_W-1:0]  entry_cnt    [ENTRIES];

    logic [IDX_W-1:0]  lk_idx;
    logic [TAG_W-1:0]  lk_tag;
    logic              lk_hit;
    logic              lk_taken;
    logic [PC_W-1:0]   lk_seq;

    logic [IDX_W-1:0]  up_idx;
    logic [TAG_W-1:0]  up_tag;
    logic              up_hit;
    logic              up_write;
    logic [CNT_W-1:0]  up_cnt_cur;
    logic [CNT_W-1:0]  up_cnt_next;
    logic [PC_W-1:0]   up_seq;
    logic [PC_W-1:0]   actual_next;
    logic [PC_W-1:0]   pred_next;
    logic              mispredict;

    logic [STAT_W-1:0] stat_br_q;
    logic [STAT_W-1:0] stat_mis_q;

    // Fetch-side lookup; reads pre-update contents, so no same-cycle bypass.
    always_comb begin
        lk_idx   = bp.if_pc[IDX_W+1:2];
        lk_tag   = bp.if_pc[TAG_W+IDX_W+1:IDX_W+2];
        lk_seq   = bp.if_pc + PC_STEP;
        lk_hit   = entry_valid[lk_idx] && (entry_tag[lk_idx] == lk_tag);
        lk_taken = lk_hit && entry_cnt[lk_idx][CNT_W-1];
    end

    assign bp.pred_hit    = lk_hit;
    assign bp.pred_taken  = lk_taken;
    assign bp.pred_target = lk_taken ? entry_target[lk_idx] : lk_seq;

    always_comb begin
        up_idx     = bp.upd_pc[IDX_W+1:2];
        up_tag     = bp.upd_pc[TAG_W+IDX_W+1:IDX_W+2];
        up_hit     = entry_valid[up_idx] && (entry_tag[up_idx] == up_tag);
        up_cnt_cur = entry_cnt[up_idx];
        // Not-taken misses leave the table alone so cold branches do not evict.
        up_write   = bp.upd_valid && (up_hit || bp.upd_taken);
    end

    always_comb begin
        up_cnt_next = up_cnt_cur;
        if (!up_hit) begin
            up_cnt_next = bp.upd_is_jump ? CNT_MAX : CNT_WEAK_T;
        end else if (bp.upd_is_jump) begin
            up_cnt_next = CNT_MAX;
        end else if (bp.upd_taken) begin
            if (up_cnt_cur != CNT_MAX) begin
                up_cnt_next = up_cnt_cur + CNT_W'(1);
            end
        end else if (up_cnt_cur != '0) begin
            up_cnt_next = up_cnt_cur - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entry_valid[i]  <= 1'b0;
                entry_tag[i]    <= '0;
                entry_target[i] <= '0;
                entry_cnt[i]    <= CNT_WEAK_NT;
            end
        end else if (up_write) begin
            entry_valid[up_idx] <= 1'b1;
            entry_tag[up_idx]   <= up_tag;
            entry_cnt[up_idx]   <= up_cnt_next;
            if (bp.upd_taken) begin
                entry_target[up_idx] <= bp.upd_target;
            end
        end
    end

    // Compare full next-PCs so a taken prediction to the wrong target also flushes.
    always_comb begin
        up_seq      = bp.upd_pc + PC_STEP;
        actual_next = bp.upd_taken ? bp.upd_target : up_seq;
        pred_next   = bp.upd_pred_taken ? bp.upd_pred_target : up_seq;
        mispredict  = bp.upd_valid && (actual_next != pred_next);
    end

    assign bp.flush       = mispredict;
    assign bp.redirect_pc = bp.upd_valid ? actual_next : '0;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else if (bp.clear_stats) begin
            stat_br_q  <= '0;
            stat_mis_q <= '0;
        end else begin
            if (bp.upd_valid && (stat_br_q != '1)) begin
                stat_br_q <= stat_br_q + STAT_W'(1);
            end
            if (mispredict && (stat_mis_q != '1)) begin
                stat_mis_q <= stat_mis_q + STAT_W'(1);
            end
        end
    end

    assign bp.stat_branches    = stat_br_q;
    assign bp.stat_mispredicts = stat_mis_q;
endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: reference table model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_branch_predictor;
    localparam int PC_W    = 64;
    localparam int ENTRIES = 16;
    localparam int TAG_W   = 8;
    localparam int CNT_W   = 2;
    localparam int STAT_W  = 4;
    localparam int CNT_TOP = 3;
    localparam int STAT_TOP = 15;

    logic clk;
    logic arst_n;
    int   n_checks;
    int   n_errors;

    branch_predictor_if #(.PC_W(PC_W), .STAT_W(STAT_W)) bpi ();

    branch_predictor #(
        .PC_W(PC_W), .ENTRIES(ENTRIES), .TAG_W(TAG_W), .CNT_W(CNT_W), .STAT_W(STAT_W)
    ) dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bp     (bpi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain arrays indexed by table slot.
    bit          m_valid  [ENTRIES];
    int          m_tag    [ENTRIES];
    logic [63:0] m_target [ENTRIES];
    int          m_cnt    [ENTRIES];
    int          m_br;
    int          m_mis;

    function automatic int slot_of(input logic [63:0] pc);
        return int'((pc / 64'd4) % 64'(ENTRIES));
    endfunction

    function automatic int tag_of(input logic [63:0] pc);
        return int'((pc / 64'(4 * ENTRIES)) % 64'(1 << TAG_W));
    endfunction

    function automatic logic [63:0] model_actual_next();
        return bpi.upd_taken ? bpi.upd_target : bpi.upd_pc + 64'd4;
    endfunction

    function automatic logic model_flush();
        logic [63:0] pn;
        pn = bpi.upd_pred_taken ? bpi.upd_pred_target : bpi.upd_pc + 64'd4;
        return bpi.upd_valid && (model_actual_next() != pn);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENTRIES; i++) begin
            m_valid[i]  = 1'b0;
            m_tag[i]    = 0;
            m_target[i] = 64'd0;
            m_cnt[i]    = 1;
        end
        m_br  = 0;
        m_mis = 0;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge arst_n) model_reset();

    always @(posedge clk) begin
        int  s;
        bit  hit;
        bit  fl;
        if (arst_n) begin
            fl = model_flush();
            if (bpi.upd_valid) begin
                s   = slot_of(bpi.upd_pc);
                hit = m_valid[s] && (m_tag[s] == tag_of(bpi.upd_pc));
                if (hit) begin
                    if (bpi.upd_is_jump)    m_cnt[s] = CNT_TOP;
                    else if (bpi.upd_taken) m_cnt[s] = (m_cnt[s] < CNT_TOP) ? m_cnt[s] + 1 : CNT_TOP;
                    else                    m_cnt[s] = (m_cnt[s] > 0) ? m_cnt[s] - 1 : 0;
                    if (bpi.upd_taken) m_target[s] = bpi.upd_target;
                end else if (bpi.upd_taken) begin
                    m_valid[s]  = 1'b1;
                    m_tag[s]    = tag_of(bpi.upd_pc);
                    m_target[s] = bpi.upd_target;
                    m_cnt[s]    = bpi.upd_is_jump ? CNT_TOP : 2;
                end
                m_br = (m_br < STAT_TOP) ? m_br + 1 : STAT_TOP;
                if (fl) m_mis = (m_mis < STAT_TOP) ? m_mis + 1 : STAT_TOP;
            end
            if (bpi.clear_stats) begin
                m_br  = 0;
                m_mis = 0;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        int          s;
        bit          eh;
        bit          et;
        logic [63:0] etgt;
        s    = slot_of(bpi.if_pc);
        eh   = m_valid[s] && (m_tag[s] == tag_of(bpi.if_pc));
        et   = eh && (m_cnt[s] >= 2);
        etgt = et ? m_target[s] : bpi.if_pc + 64'd4;
        chk("cyc_pred_hit", 64'(bpi.pred_hit), 64'(eh));
        chk("cyc_pred_taken", 64'(bpi.pred_taken), 64'(et));
        chk("cyc_pred_target", bpi.pred_target, etgt);
        chk("cyc_flush", 64'(bpi.flush), 64'(model_flush()));
        chk("cyc_redirect", bpi.redirect_pc, bpi.upd_valid ? model_actual_next() : 64'd0);
        chk("cyc_stat_br", 64'(bpi.stat_branches), 64'(m_br));
        chk("cyc_stat_mis", 64'(bpi.stat_mispredicts), 64'(m_mis));
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bpi.upd_valid       = 1'b0;
        bpi.upd_is_jump     = 1'b0;
        bpi.upd_pc          = 64'd0;
        bpi.upd_taken       = 1'b0;
        bpi.upd_target      = 64'd0;
        bpi.upd_pred_taken  = 1'b0;
        bpi.upd_pred_target = 64'd0;
    endtask

    task automatic upd(input logic jmp, input logic [63:0] pc, input logic tk,
                       input logic [63:0] tgt, input logic ptk, input logic [63:0] ptgt);
        bpi.upd_valid       = 1'b1;
        bpi.upd_is_jump     = jmp;
        bpi.upd_pc          = pc;
        bpi.upd_taken       = tk;
        bpi.upd_target      = tgt;
        bpi.upd_pred_taken  = ptk;
        bpi.upd_pred_target = ptgt;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        arst_n = 1'b0;
        idle();
        bpi.clear_stats = 1'b0;
        bpi.if_pc = 64'h100;
        #3;
        chk("in_reset_hit", 64'(bpi.pred_hit), 64'd0);
        chk("in_reset_target", bpi.pred_target, 64'h104);

        cyc(); arst_n = 1'b1; #1;
        chk("init_hit", 64'(bpi.pred_hit), 64'd0);
        chk("init_taken", 64'(bpi.pred_taken), 64'd0);
        chk("init_target", bpi.pred_target, 64'h104);
        chk("init_stat_br", 64'(bpi.stat_branches), 64'd0);
        chk("init_stat_mis", 64'(bpi.stat_mispredicts), 64'd0);

        cyc(); upd(0, 64'h100, 1, 64'h40, 0, 64'h0); #1;
        chk("train_flush", 64'(bpi.flush), 64'd1);
        chk("train_redirect", bpi.redirect_pc, 64'h40);
        chk("train_same_cycle_hit", 64'(bpi.pred_hit), 64'd0);

        cyc(); idle(); #1;
        chk("trained_hit", 64'(bpi.pred_hit), 64'd1);
        chk("trained_taken", 64'(bpi.pred_taken), 64'd1);
        chk("trained_target", bpi.pred_target, 64'h40);
        chk("trained_stat_br", 64'(bpi.stat_branches), 64'd1);
        chk("trained_stat_mis", 64'(bpi.stat_mispredicts), 64'd1);

        repeat (4) begin
            cyc(); upd(0, 64'h100, 0, 64'h0, 0, 64'h0); #1;
            chk("nt_flush", 64'(bpi.flush), 64'd0);
        end
        cyc(); idle(); #1;
        chk("nt_hit", 64'(bpi.pred_hit), 64'd1);
        chk("nt_taken", 64'(bpi.pred_taken), 64'd0);
        chk("nt_target", bpi.pred_target, 64'h104);

        bpi.if_pc = 64'h4100; #1;
        chk("alias_same_tag_hit", 64'(bpi.pred_hit), 64'd1);
        bpi.if_pc = 64'h140; #1;
        chk("alias_diff_tag_hit", 64'(bpi.pred_hit), 64'd0);

        cyc(); upd(0, 64'h200, 1, 64'h300, 0, 64'h0); bpi.if_pc = 64'h200; #1;
        chk("same_cycle_hit", 64'(bpi.pred_hit), 64'd0);
        chk("same_cycle_flush", 64'(bpi.flush), 64'd1);
        cyc(); idle(); #1;
        chk("next_cycle_hit", 64'(bpi.pred_hit), 64'd1);
        chk("next_cycle_target", bpi.pred_target, 64'h300);

        cyc(); upd(0, 64'h200, 1, 64'h300, 1, 64'h300); #1;
        chk("correct_flush", 64'(bpi.flush), 64'd0);
        cyc(); idle(); #1;
        chk("correct_stat_br", 64'(bpi.stat_branches), 64'd7);
        chk("correct_stat_mis", 64'(bpi.stat_mispredicts), 64'd2);

        cyc(); upd(1, 64'h404, 1, 64'h800, 0, 64'h0); #1;
        chk("jump_flush", 64'(bpi.flush), 64'd1);
        chk("jump_redirect", bpi.redirect_pc, 64'h800);
        cyc(); idle(); bpi.if_pc = 64'h404; #1;
        chk("jump_hit", 64'(bpi.pred_hit), 64'd1);
        chk("jump_target", bpi.pred_target, 64'h800);

        cyc(); upd(0, 64'h404, 0, 64'h0, 1, 64'h800); #1;
        chk("jump_nt_flush", 64'(bpi.flush), 64'd1);
        chk("jump_nt_redirect", bpi.redirect_pc, 64'h408);
        cyc(); idle(); #1;
        chk("jump_nt_still_taken", 64'(bpi.pred_taken), 64'd1);

        cyc(); upd(0, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 0, 64'h0);
        bpi.if_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
        chk("wrap_pred_target", bpi.pred_target, 64'h0);
        chk("wrap_flush", 64'(bpi.flush), 64'd0);
        chk("wrap_redirect", bpi.redirect_pc, 64'h0);

        repeat (20) begin
            cyc(); upd(0, 64'h500, 1, 64'h600, 0, 64'h0);
        end
        cyc(); idle(); #1;
        chk("sat_stat_br", 64'(bpi.stat_branches), 64'd15);
        chk("sat_stat_mis", 64'(bpi.stat_mispredicts), 64'd15);

        cyc(); upd(0, 64'h500, 1, 64'h600, 0, 64'h0); bpi.clear_stats = 1'b1;
        cyc(); idle(); bpi.clear_stats = 1'b0; #1;
        chk("clear_stat_br", 64'(bpi.stat_branches), 64'd0);
        chk("clear_stat_mis", 64'(bpi.stat_mispredicts), 64'd0);

        cyc(); upd(0, 64'h500, 1, 64'h700, 1, 64'h600);
        cyc(); idle(); bpi.if_pc = 64'h404; #1;
        chk("post_clear_stat_br", 64'(bpi.stat_branches), 64'd1);
        chk("post_clear_stat_mis", 64'(bpi.stat_mispredicts), 64'd1);
        chk("pre_reset_hit", 64'(bpi.pred_hit), 64'd1);

        #1; arst_n = 1'b0; #1;
        chk("mid_reset_hit", 64'(bpi.pred_hit), 64'd0);
        chk("mid_reset_target", bpi.pred_target, 64'h408);
        chk("mid_reset_stat_br", 64'(bpi.stat_branches), 64'd0);

        cyc(); cyc(); arst_n = 1'b1;
        cyc(); #1;
        chk("post_reset_hit", 64'(bpi.pred_hit), 64'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised dynamic branch predictor that replaces static opcode-driven flush decisions with a tagged branch target buffer (BTB) and a table of saturating direction counters. It is looked up combinationally by the fetch stage and trained by the execute stage. When a branch or jump resolves, it raises a flush and a redirect PC whenever the resolved next-PC differs from the predicted next-PC. It also keeps saturating statistics counters for branch and mispredict events.

## Interface
- PC_W, 64, PC width in bits.
- ENTRIES, 16, number of BTB entries; power of two, ≥2.
- TAG_W, 8, tag bits stored per entry; TAG_W + log2(ENTRIES) + 2 ≤ PC_W.
- CNT_W, 2, width of each direction counter; ≥1.
- STAT_W, 32, width of each statistics counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- arst_n  in  1  reset, asynchronous, active-low.
- if_pc  in  PC_W  fetch PC to predict.
- pred_hit  out  1  if_pc hits a valid entry with a matching tag.
- pred_taken  out  1  predicted taken.
- pred_target  out  PC_W  predicted next PC.
- upd_valid  in  1  a branch or jump resolves this cycle.
- upd_is_jump  in  1  the resolved instruction is an unconditional jump.
- upd_pc  in  PC_W  PC of the resolved instruction.
- upd_taken  in  1  actual direction (must be 1 when upd_is_jump).
- upd_target  in  PC_W  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipe for this instruction.
- upd_pred_target  in  PC_W  predicted target carried down the pipe.
- flush  out  1  mispredict: squash IF/ID and ID/EX.
- redirect_pc  out  PC_W  correct next PC; meaningful when flush=1.
- clear_stats  in  1  synchronous clear of the statistics counters.
- stat_branches  out  STAT_W  count of resolved updates.
- stat_mispredicts  out  STAT_W  count of flushes.

## Operation
- Index is pc[IDX_W+1:2] with IDX_W = log2(ENTRIES). Tag is pc[TAG_W+IDX_W+1:IDX_W+2].
- Each entry holds a valid bit, a tag, a target (PC_W bits) and a counter (CNT_W bits).
- The counter predicts taken when its MSB is 1.
- Lookup is combinational:
  - hit: pred_taken = counter MSB; pred_target = taken ? stored target : if_pc+4.
  - miss: pred_hit=0, pred_taken=0, pred_target=if_pc+4.
- Update (upd_valid=1, at the clock edge), on a hit at upd_pc:
  - upd_taken=1: counter increments, saturating at 2^CNT_W−1, and target ← upd_target.
  - upd_taken=0: counter decrements, saturating at 0; target is unchanged.
  - upd_is_jump=1: counter is forced to 2^CNT_W−1.
- Update on a miss:
  - upd_taken=1: allocate the entry (overwrite regardless of old contents). valid=1, tag, target ← upd_target, counter ← 2^(CNT_W−1) (weakly taken), or all-ones if upd_is_jump.
  - upd_taken=0: no change.
- Mispredict logic, all combinational and evaluated when upd_valid=1:
  - actual_next = upd_taken ? upd_target : upd_pc+4.
  - pred_next = upd_pred_taken ? upd_pred_target : upd_pc+4.
  - flush = (actual_next ≠ pred_next).
  - redirect_pc = actual_next.
- When upd_valid=0: flush=0 and redirect_pc=0.
- PC+4 arithmetic is modulo 2^PC_W (wraps at the top of the address space).
- Statistics counters, updated at the clock edge:
  - stat_branches increments on each upd_valid.
  - stat_mispredicts increments when flush=1.
  - Both saturate at all-ones; they never wrap.
  - clear_stats=1 zeroes both and has priority over increments in the same cycle.

## Timing
- Lookup latency: 0 cycles (combinational from if_pc).
- flush and redirect_pc: 0 cycles (combinational from the upd_* inputs).
- Table writes take effect at the rising edge and are visible to lookup the following cycle.
- Lookup and update to the same entry in the same cycle: lookup returns the pre-update contents; there is no bypass.
- Reset (arst_n=0, at any time including mid-operation), effective immediately without waiting for a clock:
  - all valid bits → 0;
  - all counters → 2^(CNT_W−1)−1 (weakly not-taken);
  - tags and targets → 0;
  - stats → 0.
- Output values while in reset: pred_hit=0, pred_taken=0, pred_target=if_pc+4; flush and redirect_pc per the upd_* rules above.
- Reset release is synchronous to clk. The first update can be accepted on the first edge after release.

## Test plan
- Reset, then if_pc=0x100 → pred_hit=0, pred_taken=0, pred_target=0x104, stat_*=0.
- Branch training:
  - Update pc=0x100, taken, target=0x40, pred_taken=0 → flush=1, redirect_pc=0x40.
  - Next cycle, lookup 0x100 → hit, taken, target 0x40.
  - Four not-taken updates → counter=0; lookup predicts not-taken, target 0x104.
- Aliasing: allocate 0x100. Lookup 0x100+ENTRIES·4·2^TAG_W (same index, same tag) → hit. Lookup 0x100+ENTRIES·4 (same index, different tag) → miss.
- Same-cycle lookup and update on pc=0x200 (first allocation) → that cycle pred_hit=0; next cycle pred_hit=1.
- Correct prediction: update with upd_pred_taken=1 and upd_pred_target equal to upd_target → flush=0, stat_branches+1, stat_mispredicts unchanged.
- Stats and reset:
  - With STAT_W=4, 20 mispredicting updates → both stats saturate at 15.
  - clear_stats together with an update → both stats read 0.
  - Drop arst_n mid-sequence → all hits vanish immediately.
